pyseq_gen: RTL and testbench

//  Parametrised payload bit sequencer for BR/EDR packets; successor to the fixed FEC2/3 (15,10) payload counter.

---
 rtl/pyseq_gen.sv | 215 +++++++++++++++++++++
 tb/tb_pyseq_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pyseq_gen.sv
// Payload bit sequencer for BR/EDR packets: payload timing (data/parity/CRC periods,
// FEC block ends, end pulse, EDR trailer) plus RX bit packing into addressed words.
module pyseq_gen #(
  parameter int unsigned FEC_K    = 10,
  parameter int unsigned FEC_N    = 15,
  parameter int unsigned LEN_W    = 13,
  parameter int unsigned CRC_LEN  = 16,
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TRL_DPSK = 4,
  parameter int unsigned TRL_8PSK = 6
) (
  input  logic              clk_6m_i,
  input  logic              rst_i,
  input  logic              py_datvalid_p_i,
  input  logic              py_st_p_i,
  input  logic              dir_rx_i,
  input  logic [1:0]        fec_mode_i,
  input  logic              crcencode_i,
  input  logic              edr_i,
  input  logic              dpsk_i,
  input  logic [LEN_W-1:0]  pylenbit_i,
  input  logic              rxbit_dec_i,
  output logic              py_period_o,
  output logic              daten_o,
  output logic              paren_o,
  output logic [LEN_W-1:0]  pybitcount_o,
  output logic              py_datperiod_o,
  output logic              py_crc16period_o,
  output logic              blk_endp_o,
  output logic              py_endp_o,
  output logic              trailer_o,
  output logic              trailer_endp_o,
  output logic [WORD_W-1:0] rxword_o,
  output logic              rxword_valid_p_o,
  output logic [ADDR_W-1:0] rxword_adr_o
);

  localparam int unsigned BlkW   = $clog2(FEC_N);
  localparam int unsigned CntW   = LEN_W + 1;
  localparam int unsigned TrlMax = (TRL_8PSK > TRL_DPSK) ? TRL_8PSK : TRL_DPSK;
  localparam int unsigned TrlW   = $clog2(TrlMax + 1);
  localparam int unsigned FillW  = $clog2(WORD_W);

  localparam logic [BlkW-1:0]  BlkK      = BlkW'(FEC_K);
  localparam logic [BlkW-1:0]  BlkLast23 = BlkW'(FEC_N - 1);
  localparam logic [BlkW-1:0]  BlkLastK  = BlkW'(FEC_K - 1);
  localparam logic [TrlW-1:0]  TrlLastD  = TrlW'(TRL_DPSK - 1);
  localparam logic [TrlW-1:0]  TrlLast8  = TrlW'(TRL_8PSK - 1);
  localparam logic [FillW-1:0] FillLast  = FillW'(WORD_W - 1);
  localparam logic [CntW-1:0]  CrcBits   = CntW'(CRC_LEN);

  typedef enum logic [1:0] {StIdle, StData, StTrail} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CntW-1:0]    total_q, total_d;
  logic [BlkW-1:0]    blkcnt_q, blkcnt_d;
  logic [1:0]         rep_q, rep_d;
  // Kept one bit wider than the port so FEC2/3 filler beyond total cannot wrap.
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [TrlW-1:0]    trl_cnt_q, trl_cnt_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic               pad_q, pad_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  adr_q, adr_d;

  logic fec23, fec13, in_data, in_trail, start, strobe_data, is_dat, adv, pack;
  logic blk_endp, py_endp, trailer_endp;
  logic [BlkW-1:0] blk_last;

  // Decode of strobe qualifiers and payload timing pulses.
  always_comb begin
    fec23       = (fec_mode_i == 2'b10);
    fec13       = (fec_mode_i == 2'b01);
    in_data     = (state_q == StData);
    in_trail    = (state_q == StTrail);
    start       = py_st_p_i && (pylenbit_i != '0);
    strobe_data = py_datvalid_p_i && in_data;
    is_dat      = (blkcnt_q < BlkK);
    blk_last    = fec23 ? BlkLast23 : BlkLastK;
    adv         = strobe_data && is_dat && (!fec13 || (rep_q == 2'd2));
    pack        = dir_rx_i && adv && (cnt_q < total_q);
    blk_endp    = strobe_data && fec23 && (blkcnt_q == BlkLast23);
    // At a block end every data position of the block has already advanced cnt_q,
    // so cnt_q equals blocks_done*FEC_K here.
    if (fec23) py_endp = blk_endp && (cnt_q >= total_q);
    else       py_endp = adv && (cnt_q == total_q - CntW'(1));
    trailer_endp = py_datvalid_p_i && in_trail &&
                   (trl_cnt_q == (dpsk_i ? TrlLastD : TrlLast8));
  end

  // FSM state register.
  always_ff @(posedge clk_6m_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next state; a valid start pulse wins in every state.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StData;
    end else begin
      unique case (state_q)
        StData:  if (py_endp) state_d = edr_i ? StTrail : StIdle;
        StTrail: if (trailer_endp) state_d = StIdle;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    py_period_o      = in_data;
    trailer_o        = in_trail;
    daten_o          = in_data && is_dat;
    paren_o          = in_data && !is_dat;
    blk_endp_o       = blk_endp;
    py_endp_o        = py_endp;
    trailer_endp_o   = trailer_endp;
    pybitcount_o     = cnt_q[LEN_W-1:0];
    py_datperiod_o   = in_data && (cnt_q < {1'b0, len_q});
    py_crc16period_o = in_data && (cnt_q >= {1'b0, len_q}) && (cnt_q < total_q);
  end

  // Next state of the block, repetition, bit and trailer counters.
  always_comb begin
    len_d     = len_q;
    total_d   = total_q;
    blkcnt_d  = blkcnt_q;
    rep_d     = rep_q;
    cnt_d     = cnt_q;
    trl_cnt_d = trl_cnt_q;
    if (start) begin
      len_d     = pylenbit_i;
      total_d   = {1'b0, pylenbit_i} + (crcencode_i ? CrcBits : '0);
      blkcnt_d  = '0;
      rep_d     = '0;
      cnt_d     = '0;
      trl_cnt_d = '0;
    end else begin
      if (strobe_data) begin
        blkcnt_d = (blkcnt_q == blk_last) ? '0 : blkcnt_q + BlkW'(1);
        if (fec13) rep_d = (rep_q == 2'd2) ? 2'd0 : rep_q + 2'd1;
      end
      if (adv) cnt_d = cnt_q + CntW'(1);
      if (py_datvalid_p_i && in_trail) trl_cnt_d = trl_cnt_q + TrlW'(1);
      if (py_endp || trailer_endp) trl_cnt_d = '0;
    end
  end

  // Next state of the RX packer: shift data bits, then zero-pad a partial last word.
  always_comb begin
    word_d  = word_q;
    fill_d  = fill_q;
    pad_d   = pad_q;
    adr_d   = adr_q;
    valid_d = 1'b0;
    if (!dir_rx_i || start) begin
      word_d = '0;
      fill_d = '0;
      pad_d  = 1'b0;
      adr_d  = '0;
    end else begin
      if (valid_q) adr_d = adr_q + ADDR_W'(1);
      if (pack || pad_q) begin
        word_d = {pack ? rxbit_dec_i : 1'b0, word_q[WORD_W-1:1]};
        if (fill_q == FillLast) begin
          fill_d  = '0;
          valid_d = 1'b1;
          pad_d   = 1'b0;
        end else begin
          fill_d = fill_q + FillW'(1);
        end
      end
      if (py_endp && (fill_d != '0)) pad_d = 1'b1;
    end
  end

  // Datapath and counter registers.
  always_ff @(posedge clk_6m_i) begin
    if (rst_i) begin
      len_q     <= '0;
      total_q   <= '0;
      blkcnt_q  <= '0;
      rep_q     <= '0;
      cnt_q     <= '0;
      trl_cnt_q <= '0;
      word_q    <= '0;
      fill_q    <= '0;
      pad_q     <= 1'b0;
      valid_q   <= 1'b0;
      adr_q     <= '0;
    end else begin
      len_q     <= len_d;
      total_q   <= total_d;
      blkcnt_q  <= blkcnt_d;
      rep_q     <= rep_d;
      cnt_q     <= cnt_d;
      trl_cnt_q <= trl_cnt_d;
      word_q    <= word_d;
      fill_q    <= fill_d;
      pad_q     <= pad_d;
      valid_q   <= valid_d;
      adr_q     <= adr_d;
    end
  end

  assign rxword_o         = word_q;
  assign rxword_valid_p_o = valid_q;
  assign rxword_adr_o     = adr_q;

endmodule

// File: tb/tb_pyseq_gen.sv
// Scoreboarded bench for pyseq_gen: directed packets, expected RX words queued up front.
module tb_pyseq_gen;

  localparam int unsigned LEN_W  = 13;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              py_datvalid_p, py_st_p, dir_rx, crcencode, edr, dpsk, rxbit_dec;
  logic [1:0]        fec_mode;
  logic [LEN_W-1:0]  pylenbit;
  logic              py_period, daten, paren, py_datperiod, py_crc16period;
  logic              blk_endp, py_endp, trailer, trailer_endp, rxword_valid_p;
  logic [LEN_W-1:0]  pybitcount;
  logic [WORD_W-1:0] rxword;
  logic [ADDR_W-1:0] rxword_adr;

  pyseq_gen dut (
    .clk_6m_i         (clk),
    .rst_i            (rst),
    .py_datvalid_p_i  (py_datvalid_p),
    .py_st_p_i        (py_st_p),
    .dir_rx_i         (dir_rx),
    .fec_mode_i       (fec_mode),
    .crcencode_i      (crcencode),
    .edr_i            (edr),
    .dpsk_i           (dpsk),
    .pylenbit_i       (pylenbit),
    .rxbit_dec_i      (rxbit_dec),
    .py_period_o      (py_period),
    .daten_o          (daten),
    .paren_o          (paren),
    .pybitcount_o     (pybitcount),
    .py_datperiod_o   (py_datperiod),
    .py_crc16period_o (py_crc16period),
    .blk_endp_o       (blk_endp),
    .py_endp_o        (py_endp),
    .trailer_o        (trailer),
    .trailer_endp_o   (trailer_endp),
    .rxword_o         (rxword),
    .rxword_valid_p_o (rxword_valid_p),
    .rxword_adr_o     (rxword_adr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WORD_W-1:0] w;
    logic [ADDR_W-1:0] a;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int gap      = 3;
  int n_pulse, n_blk, n_pyend, n_trlend, n_daten, n_paren, endp_blk, endp_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Event counters and scoreboard pop, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (blk_endp) n_blk++;
      if (py_endp) begin
        n_pyend++;
        endp_blk = n_blk;
        endp_cnt = int'(pybitcount);
      end
      if (trailer_endp) n_trlend++;
      if (py_datvalid_p && py_period && daten) n_daten++;
      if (py_datvalid_p && py_period && paren) n_paren++;
      if (rxword_valid_p) begin
        n_pulse++;
        if (exp_q.size() == 0) begin
          check("stray_rxword_valid", 64'(rxword_adr), 64'hFFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rxword", 64'(rxword), 64'(e.w));
          check("rxword_adr", 64'(rxword_adr), 64'(e.a));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    n_pulse = 0; n_blk = 0; n_pyend = 0; n_trlend = 0;
    n_daten = 0; n_paren = 0; endp_blk = -1; endp_cnt = -1;
  endtask

  task automatic start(input int len, input bit crc, input logic [1:0] fec,
                       input bit e, input bit d, input bit rx);
    clr_mon();
    pylenbit = LEN_W'(len); crcencode = crc; fec_mode = fec;
    edr = e; dpsk = d; dir_rx = rx;
    py_st_p = 1'b1;
    tick(1);
    py_st_p = 1'b0;
    tick(1);
  endtask

  task automatic strobe(input bit b);
    py_datvalid_p = 1'b1;
    rxbit_dec     = b;
    tick(1);
    py_datvalid_p = 1'b0;
    tick(gap - 1);
  endtask

  task automatic drain(input int max_clk);
    for (int i = 0; i < max_clk && exp_q.size() != 0; i++) tick(1);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [23:0] v24;
    logic [63:0] v64;
    logic [7:0]  v8;
    logic [3:0]  v4;
    int n;
    rst = 1'b1; py_datvalid_p = 1'b0; py_st_p = 1'b0; dir_rx = 1'b0;
    crcencode = 1'b0; edr = 1'b0; dpsk = 1'b0; rxbit_dec = 1'b0;
    fec_mode = 2'b00; pylenbit = '0;
    clr_mon();
    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset_py_period", 64'(py_period), 64'd0);
    check("reset_pybitcount", 64'(pybitcount), 64'd0);
    check("reset_trailer", 64'(trailer), 64'd0);
    check("reset_rxword", 64'(rxword), 64'd0);
    check("reset_rxword_adr", 64'(rxword_adr), 64'd0);

    // FEC2/3, len 144, TX, strobe every 6 clocks: 15 blocks of 15 strobes.
    gap = 6;
    start(144, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    check("t1_py_period", 64'(py_period), 64'd1);
    n = 0;
    do begin
      strobe(1'b1);
      n++;
    end while (py_period && n < 300);
    check("t1_strobes", 64'(n), 64'd225);
    check("t1_blk_endp", 64'(n_blk), 64'd15);
    check("t1_py_endp", 64'(n_pyend), 64'd1);
    check("t1_endp_blk", 64'(endp_blk), 64'd15);
    check("t1_daten", 64'(n_daten), 64'd150);
    check("t1_paren", 64'(n_paren), 64'd75);
    check("t1_pybitcount", 64'(pybitcount), 64'd150);
    check("t1_tx_rxword", 64'(rxword), 64'd0);
    gap = 3;

    // No FEC, len 8 + CRC, RX: 24 bits then 8 zero pad bits.
    v24 = 24'hB46ED3;
    exp_q.push_back('{w: {8'h00, v24}, a: 8'd0});
    start(8, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) begin
      strobe(v24[i]);
      if (i == 2) check("t2_datperiod", 64'(py_datperiod), 64'd1);
      if (i == 7) begin
        check("t2_datperiod_end", 64'(py_datperiod), 64'd0);
        check("t2_crcperiod", 64'(py_crc16period), 64'd1);
      end
    end
    check("t2_py_endp", 64'(n_pyend), 64'd1);
    check("t2_endp_cnt", 64'(endp_cnt), 64'd23);
    drain(60);
    tick(10);
    check("t2_pulses", 64'(n_pulse), 64'd1);

    // FEC1/3, len 4, RX bits 1,0,1,1 each sent over three strobes.
    v4 = 4'b1101;
    exp_q.push_back('{w: 32'h0000000D, a: 8'd0});
    start(4, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < 3; r++) begin
        strobe(v4[i]);
        if (i == 0 && r == 1) check("t3_cnt_rep1", 64'(pybitcount), 64'd0);
        if (i == 0 && r == 2) check("t3_cnt_rep2", 64'(pybitcount), 64'd1);
      end
    end
    check("t3_pybitcount", 64'(pybitcount), 64'd4);
    drain(80);

    // EDR trailers: 4 strobes for DQPSK, 6 for 8DPSK.
    for (int k = 0; k < 2; k++) begin
      start(2, 1'b0, 2'b00, 1'b1, (k == 0), 1'b0);
      strobe(1'b0);
      strobe(1'b1);
      check("t4_trailer_on", 64'(trailer), 64'd1);
      n = 0;
      while (trailer && n < 20) begin
        strobe(1'b0);
        n++;
      end
      check("t4_trailer_strobes", 64'(n), (k == 0) ? 64'd4 : 64'd6);
      check("t4_trailer_endp", 64'(n_trlend), 64'd1);
      check("t4_idle", 64'(py_period), 64'd0);
    end

    // RX len 64: two full words, no padding; then a zero-length start.
    v64 = 64'hDEADBEEF_01234567;
    exp_q.push_back('{w: v64[31:0], a: 8'd0});
    exp_q.push_back('{w: v64[63:32], a: 8'd1});
    start(64, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) strobe(v64[i]);
    drain(20);
    tick(40);
    check("t5_pulses", 64'(n_pulse), 64'd2);
    start(0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    strobe(1'b1);
    check("t5_len0_period", 64'(py_period), 64'd0);
    check("t5_len0_cnt", 64'(pybitcount), 64'd64);

    // Reset mid-packet, then restart mid-packet.
    start(40, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) strobe(1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    check("t6_rst_cnt", 64'(pybitcount), 64'd0);
    check("t6_rst_period", 64'(py_period), 64'd0);
    check("t6_rst_rxword", 64'(rxword), 64'd0);
    tick(40);
    check("t6_rst_no_pulse", 64'(n_pulse), 64'd0);
    exp_q.push_back('{w: 32'hFFFFFFFF, a: 8'd0});
    start(40, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 33; i++) strobe(1'b1);
    v8 = 8'h5A;
    exp_q.push_back('{w: {24'h0, v8}, a: 8'd0});
    start(8, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    check("t6_restart_cnt", 64'(pybitcount), 64'd0);
    check("t6_restart_period", 64'(py_period), 64'd1);
    for (int i = 0; i < 8; i++) strobe(v8[i]);
    drain(60);
    tick(10);
    check("t6_restart_pulses", 64'(n_pulse), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
